// File: rtl/score_digitizer_pkg.sv
// ---------------------------------------------------------------------------
// score_digitizer_pkg
//   Shared sizes, state encoding and helpers for the score digitizer.
//   SCORE_W   : width of the binary score coming from the game logic
//   DIGITS    : number of packed BCD digits handed to the page renderer
//   SCORE_MAX : largest score that can be shown; larger values saturate
// ---------------------------------------------------------------------------
package score_digitizer_pkg;

  localparam int SCORE_W   = 14;
  localparam int DIGITS    = 4;
  localparam int SCORE_MAX = 9999;

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);

  // Saturation limit at the same width as the score, so compares stay
  // width-matched.
  localparam logic [SCORE_W-1:0] SCORE_MAX_W = SCORE_W'(SCORE_MAX);

  // Reset value of the blanking mask: only the units digit is lit.
  localparam logic [DIGITS-1:0] EN_RESET = {{(DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    SD_IDLE  = 2'd0,
    SD_SHIFT = 2'd1,
    SD_PEND  = 2'd2
  } sd_state_t;

  // Leading-zero blanking. A digit is lit when it or any more significant
  // digit is nonzero. Scanning from the top down with a sticky "seen" flag
  // gives exactly that. Units is always lit so a zero score shows "0".
  function automatic logic [DIGITS-1:0] blankMask(input logic [BCD_W-1:0] bcd);
    logic [DIGITS-1:0] en;
    logic              seen;
    en   = '0;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seen  = seen | (bcd[4*i +: 4] != 4'd0);
      en[i] = seen;
    end
    en[0] = 1'b1;
    return en;
  endfunction

endpackage

// File: rtl/score_digitizer_bcd_dabble_step.sv
// ---------------------------------------------------------------------------
// bcd_dabble_step
//   One combinational double-dabble iteration. Every BCD nibble that is 5 or
//   more is corrected by +3, then the BCD and binary registers are shifted
//   left together by one bit. The top binary bit moves into the BCD units.
//   Ports:
//     i_bcd : current BCD accumulator (DIGITS nibbles, [3:0] = units)
//     i_bin : remaining binary bits, MSB consumed next
//     o_bcd : accumulator after adjust and shift
//     o_bin : binary register after shift
// ---------------------------------------------------------------------------
module bcd_dabble_step
  import score_digitizer_pkg::*;
(
  input  logic [BCD_W-1:0]   i_bcd,
  input  logic [SCORE_W-1:0] i_bin,
  output logic [BCD_W-1:0]   o_bcd,
  output logic [SCORE_W-1:0] o_bin
);

  logic [BCD_W-1:0] w_adj;

  // The +3 correction happens before the shift. A nibble of 5..9 would
  // become 10..18 after doubling, so adding 3 first makes the doubled value
  // carry cleanly into the next decimal digit.
  always_comb begin
    w_adj = i_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (i_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = i_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // The BCD MSB falls off the top. It is always zero because the converted
  // value is saturated to fit in DIGITS decimal digits.
  assign {o_bcd, o_bin} = {w_adj, i_bin} << 1;

endmodule

// File: rtl/score_digitizer.sv
// ---------------------------------------------------------------------------
// score_digitizer
//   Turns the binary game score into packed BCD digits plus a leading-zero
//   blanking mask for the end/HUD page renderer. The conversion runs as a
//   sequential double-dabble (one bit per cycle). The result is published
//   only when a frame starts, so the renderer never sees digits change
//   partway through a frame. A request that arrives while busy waits in a
//   single-entry slot; a newer request replaces an older one there.
//   Ports:
//     vga_clk     : pixel clock, the only clock
//     sys_rst     : synchronous reset, active-high
//     score_in    : binary score, sampled when score_vld is high
//     score_vld   : single-cycle conversion request
//     frame_start : single-cycle pulse at the first pixel of each frame
//     busy        : high while converting or waiting for frame_start
//     digit_bcd   : published BCD digits, [3:0] is units
//     digit_en    : published per-digit enable (leading-zero blanking)
//     overflow    : published score was above SCORE_MAX
// ---------------------------------------------------------------------------
module score_digitizer
  import score_digitizer_pkg::*;
(
  input  logic               vga_clk,
  input  logic               sys_rst,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               score_vld,
  input  logic               frame_start,
  output logic               busy,
  output logic [BCD_W-1:0]   digit_bcd,
  output logic [DIGITS-1:0]  digit_en,
  output logic               overflow
);

  sd_state_t r_state;
  sd_state_t w_nextState;

  logic               r_pendVld;
  logic [SCORE_W-1:0] r_pendVal;

  logic [BCD_W-1:0]   r_bcd;
  logic [SCORE_W-1:0] r_bin;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_cnt;

  logic [BCD_W-1:0]   r_digitBcd;
  logic [DIGITS-1:0]  r_digitEn;
  logic               r_overflow;

  logic               w_start;
  logic               w_publish;
  logic [SCORE_W-1:0] w_src;
  logic               w_srcOvf;
  logic [SCORE_W-1:0] w_clamped;
  logic [BCD_W-1:0]   w_stepBcd;
  logic [SCORE_W-1:0] w_stepBin;

  // Next-state and control decode. In IDLE a live request beats the pending
  // slot. Without a live request, a full slot starts a conversion by itself.
  // This is how a request parked while busy gets served in the first IDLE
  // cycle after publishing.
  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_publish   = 1'b0;
    w_src       = score_in;
    case (r_state)
      SD_IDLE: begin
        if (score_vld) begin
          w_start = 1'b1;
          w_src   = score_in;
        end else if (r_pendVld) begin
          w_start = 1'b1;
          w_src   = r_pendVal;
        end
        if (w_start) begin
          w_nextState = SD_SHIFT;
        end
      end
      SD_SHIFT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_nextState = SD_PEND;
        end
      end
      SD_PEND: begin
        if (frame_start) begin
          w_publish   = 1'b1;
          w_nextState = SD_IDLE;
        end
      end
      default: begin
        w_nextState = SD_IDLE;
      end
    endcase
  end

  // Saturate before converting so the result always fits in DIGITS digits.
  assign w_srcOvf  = (w_src > SCORE_MAX_W);
  assign w_clamped = w_srcOvf ? SCORE_MAX_W : w_src;

  // State register.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_state <= SD_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Single-entry pending slot. A request seen while busy always overwrites
  // the slot, so only the latest one survives. The slot empties once IDLE
  // starts a conversion. If a live request wins in IDLE, the parked value
  // is superseded and dropped as well.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_pendVld <= 1'b0;
      r_pendVal <= '0;
    end else if ((r_state != SD_IDLE) && score_vld) begin
      r_pendVld <= 1'b1;
      r_pendVal <= score_in;
    end else if (w_start) begin
      r_pendVld <= 1'b0;
    end
  end

  bcd_dabble_step u_step (
    .i_bcd (r_bcd),
    .i_bin (r_bin),
    .o_bcd (w_stepBcd),
    .o_bin (w_stepBin)
  );

  // Conversion datapath. Starting a conversion loads the clamped value and
  // arms the counter for SCORE_W steps. Each SHIFT cycle applies one dabble
  // step. The finished digits stay in r_bcd through PEND until publishing.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_bcd <= '0;
      r_bin <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (w_start) begin
      r_bcd <= '0;
      r_bin <= w_clamped;
      r_ovf <= w_srcOvf;
      r_cnt <= CNT_W'(SCORE_W);
    end else if (r_state == SD_SHIFT) begin
      r_bcd <= w_stepBcd;
      r_bin <= w_stepBin;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Published outputs. These change only on the PEND to IDLE transition, so
  // digits, blanking mask and overflow always update together.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_digitBcd <= '0;
      r_digitEn  <= EN_RESET;
      r_overflow <= 1'b0;
    end else if (w_publish) begin
      r_digitBcd <= r_bcd;
      r_digitEn  <= blankMask(r_bcd);
      r_overflow <= r_ovf;
    end
  end

  assign busy      = (r_state != SD_IDLE);
  assign digit_bcd = r_digitBcd;
  assign digit_en  = r_digitEn;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_score_digitizer.sv
// ---------------------------------------------------------------------------
// tb_score_digitizer
//   Self-checking bench for score_digitizer. A table of hand-computed vectors
//   is applied first. Hand-written sequences follow for pending-slot,
//   mid-conversion frame and reset corner cases. Random scores are then
//   checked against a decimal reference model.
// ---------------------------------------------------------------------------
module tb_score_digitizer;
  import score_digitizer_pkg::*;

  logic               vga_clk = 1'b0;
  logic               sys_rst;
  logic [SCORE_W-1:0] score_in;
  logic               score_vld;
  logic               frame_start;
  logic               busy;
  logic [BCD_W-1:0]   digit_bcd;
  logic [DIGITS-1:0]  digit_en;
  logic               overflow;

  int checkCount = 0;
  int failCount  = 0;

  logic [15:0] expBcd;
  logic [3:0]  expEn;
  logic        expOvf;

  typedef struct {
    int          score;
    logic [15:0] bcd;
    logic [3:0]  en;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  score_digitizer dut (
    .vga_clk     (vga_clk),
    .sys_rst     (sys_rst),
    .score_in    (score_in),
    .score_vld   (score_vld),
    .frame_start (frame_start),
    .busy        (busy),
    .digit_bcd   (digit_bcd),
    .digit_en    (digit_en),
    .overflow    (overflow)
  );

  // Free-running pixel clock.
  always #5 vga_clk = ~vga_clk;

  // Hard stop in case a sequence never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // Decimal reference model built from plain arithmetic.
  function automatic int clampScore(int s);
    return (s > 9999) ? 9999 : s;
  endfunction

  function automatic logic [15:0] refBcd(int s);
    int v;
    logic [15:0] r;
    v        = clampScore(s);
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic logic [3:0] refEn(int s);
    int v;
    logic [3:0] en;
    v  = clampScore(s);
    en = 4'b0001;
    if (v >= 10)   en[1] = 1'b1;
    if (v >= 100)  en[2] = 1'b1;
    if (v >= 1000) en[3] = 1'b1;
    return en;
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  // Compare all outputs at once.
  task automatic checkOutput(input string name, input logic [15:0] eBcd,
                             input logic [3:0] eEn, input logic eOvf,
                             input logic eBusy);
    checkCount++;
    if ({digit_bcd, digit_en, overflow, busy} !== {eBcd, eEn, eOvf, eBusy}) begin
      failCount++;
      $display("[TB] FAIL %s: got bcd=%h en=%b ovf=%b busy=%b, want bcd=%h en=%b ovf=%b busy=%b",
               name, digit_bcd, digit_en, overflow, busy, eBcd, eEn, eOvf, eBusy);
    end
  endtask

  // Pulse score_vld for one cycle. Returns at cycle t+1.
  task automatic applyStimulus(input int s);
    score_in  = SCORE_W'(s);
    score_vld = 1'b1;
    tick();
    score_vld = 1'b0;
  endtask

  task automatic pulseFrame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Full request: busy at t+1, still old outputs in PEND at t+15,
  // frame_start at t+15, new outputs and busy low at t+16.
  task automatic convertAndPublish(input string name, input int s,
                                   input logic [15:0] eBcd, input logic [3:0] eEn,
                                   input logic eOvf);
    applyStimulus(s);
    checkOutput($sformatf("%s_busy", name), expBcd, expEn, expOvf, 1'b1);
    repeat (14) tick();
    checkOutput($sformatf("%s_pend", name), expBcd, expEn, expOvf, 1'b1);
    pulseFrame();
    expBcd = eBcd;
    expEn  = eEn;
    expOvf = eOvf;
    checkOutput(name, expBcd, expEn, expOvf, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{0,     16'h0000, 4'b0001, 1'b0};
    vecs[1]  = '{9,     16'h0009, 4'b0001, 1'b0};
    vecs[2]  = '{10,    16'h0010, 4'b0011, 1'b0};
    vecs[3]  = '{99,    16'h0099, 4'b0011, 1'b0};
    vecs[4]  = '{100,   16'h0100, 4'b0111, 1'b0};
    vecs[5]  = '{1000,  16'h1000, 4'b1111, 1'b0};
    vecs[6]  = '{1234,  16'h1234, 4'b1111, 1'b0};
    vecs[7]  = '{9999,  16'h9999, 4'b1111, 1'b0};
    vecs[8]  = '{10000, 16'h9999, 4'b1111, 1'b1};
    vecs[9]  = '{12000, 16'h9999, 4'b1111, 1'b1};
    vecs[10] = '{7,     16'h0007, 4'b0001, 1'b0};
    vecs[11] = '{16383, 16'h9999, 4'b1111, 1'b1};

    sys_rst     = 1'b1;
    score_in    = '0;
    score_vld   = 1'b0;
    frame_start = 1'b0;
    repeat (3) tick();
    sys_rst = 1'b0;
    tick();

    // Reset state, unchanged across idle frames.
    expBcd = 16'h0000;
    expEn  = 4'b0001;
    expOvf = 1'b0;
    checkOutput("reset", expBcd, expEn, expOvf, 1'b0);
    for (int f = 0; f < 3; f++) begin
      repeat (5) tick();
      pulseFrame();
      checkOutput($sformatf("idle_frame%0d", f), expBcd, expEn, expOvf, 1'b0);
    end

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      convertAndPublish($sformatf("vec%0d_%0d", i, vecs[i].score), vecs[i].score,
                        vecs[i].bcd, vecs[i].en, vecs[i].ovf);
    end

    // Pending slot: 57, then 300 and 42 while busy. 300 is superseded.
    applyStimulus(57);
    repeat (2) tick();
    applyStimulus(300);
    repeat (2) tick();
    applyStimulus(42);
    repeat (8) tick();
    pulseFrame();
    expBcd = 16'h0057; expEn = 4'b0011; expOvf = 1'b0;
    checkOutput("pend_first", expBcd, expEn, expOvf, 1'b0);
    tick();
    checkOutput("pend_restart", expBcd, expEn, expOvf, 1'b1);
    repeat (14) tick();
    pulseFrame();
    expBcd = 16'h0042; expEn = 4'b0011; expOvf = 1'b0;
    checkOutput("pend_latest", expBcd, expEn, expOvf, 1'b0);
    repeat (3) tick();
    pulseFrame();
    checkOutput("pend_drained", expBcd, expEn, expOvf, 1'b0);

    // frame_start during SHIFT is ignored; PEND waits for the next frame.
    applyStimulus(2468);
    repeat (4) tick();
    pulseFrame();
    checkOutput("shift_frame", expBcd, expEn, expOvf, 1'b1);
    repeat (12) tick();
    checkOutput("pend_hold", expBcd, expEn, expOvf, 1'b1);
    pulseFrame();
    expBcd = 16'h2468; expEn = 4'b1111; expOvf = 1'b0;
    checkOutput("late_publish", expBcd, expEn, expOvf, 1'b0);

    // score_vld and frame_start together in IDLE: start, no output change.
    score_in    = SCORE_W'(555);
    score_vld   = 1'b1;
    frame_start = 1'b1;
    tick();
    score_vld   = 1'b0;
    frame_start = 1'b0;
    checkOutput("vld_and_frame", expBcd, expEn, expOvf, 1'b1);
    repeat (14) tick();
    pulseFrame();
    expBcd = 16'h0555; expEn = 4'b0111; expOvf = 1'b0;
    checkOutput("vld_and_frame_pub", expBcd, expEn, expOvf, 1'b0);

    // Reset during SHIFT with a request parked in the slot.
    applyStimulus(8765);
    repeat (2) tick();
    applyStimulus(4321);
    repeat (4) tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    expBcd = 16'h0000; expEn = 4'b0001; expOvf = 1'b0;
    checkOutput("mid_reset", expBcd, expEn, expOvf, 1'b0);
    for (int f = 0; f < 4; f++) begin
      repeat (9) tick();
      pulseFrame();
      checkOutput($sformatf("post_reset%0d", f), expBcd, expEn, expOvf, 1'b0);
    end

    // Random scores against the reference model, biased near saturation.
    for (int n = 0; n < 40; n++) begin
      int s;
      if ($urandom_range(0, 3) == 0) s = int'($urandom_range(9990, 10010));
      else                           s = int'($urandom_range(0, 16383));
      repeat ($urandom_range(0, 3)) tick();
      convertAndPublish($sformatf("rand%0d_%0d", n, s), s, refBcd(s), refEn(s), s > 9999);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/score_digitizer.md
# score_digitizer

Converts the binary game score into four packed BCD digits with a leading-zero blanking mask, for use by the end-of-game page renderer. It runs a sequential double-dabble conversion and publishes results only on a frame boundary, so the digits never change mid-frame. It sits between the game logic, which produces the score, and the end/HUD page pixel generator, which consumes the digits.

## Interface
- SCORE_W, 14, width of the binary score input.
- DIGITS, 4, number of BCD digits produced.
- SCORE_MAX, 9999, saturation limit.

- vga_clk  in  1  pixel clock; the only clock.
- sys_rst  in  1  synchronous reset, active-high.
- score_in  in  SCORE_W  binary score; sampled only when score_vld=1.
- score_vld  in  1  single-cycle request to convert score_in.
- frame_start  in  1  single-cycle pulse at the first pixel of each frame.
- busy  out  1  high when not IDLE (converting or awaiting frame_start).
- digit_bcd  out  4*DIGITS  BCD digits; [3:0] is units.
- digit_en  out  DIGITS  per-digit display enable (leading-zero blanking).
- overflow  out  1  last published score exceeded SCORE_MAX.

## Operation
- FSM: IDLE, SHIFT, PEND.
- IDLE:
  - Enter SHIFT when score_vld=1 or the pending slot is full; score_vld takes priority and clears the slot.
  - Capture val = min(value, SCORE_MAX) and ovf = (value > SCORE_MAX).
  - Clear the BCD accumulator and set the bit counter to SCORE_W.
- SHIFT: one double-dabble step per cycle.
  - Each BCD nibble ≥5 gets +3.
  - Then shift {bcd, bin} left by 1.
  - Decrement the counter; after SCORE_W steps go to PEND.
- PEND: hold the staged result.
  - On frame_start, copy to digit_bcd, digit_en and overflow, then go to IDLE.
- score_vld while busy: store score_in in a single-entry pending slot; a later request overwrites it (latest wins). No request is dropped except one that is superseded.
- digit_en[0] is always 1. digit_en[i] for i>0 is 1 iff any digit at index ≥ i is nonzero. It is computed from the staged digits and published together with them.
- frame_start outside PEND has no effect.
- Outputs change only on the PEND→IDLE transition or on reset.
- Reset values: all state cleared.
  - State IDLE, pending slot empty, busy=0.
  - digit_bcd=0, digit_en=4'b0001, overflow=0.
  - Reset mid-operation discards the conversion in flight and the pending request.

## Timing
- score_vld at cycle t in IDLE: busy=1 from t+1; SHIFT occupies t+1..t+SCORE_W (14 cycles); PEND from t+15.
- If frame_start is high in the first PEND cycle (t+15), outputs are valid at t+16. Otherwise outputs update the cycle after the first frame_start seen in PEND.
- busy falls in the same cycle that the outputs update.
- A pending request starts in the first IDLE cycle (busy stays low for exactly that one cycle). It is then handled as a score_vld issued in that cycle.
- score_vld and frame_start together in IDLE: conversion starts and outputs are unchanged.
- Worst-case latency: 15 cycles plus up to one frame.

## Structure
- Shared definitions go in define.vh:
  - SCORE_W, DIGITS, SCORE_MAX.
  - State encodings SD_IDLE, SD_SHIFT, SD_PEND.
- One natural sub-module, bcd_dabble_step: combinational; one nibble-adjust-and-shift step over DIGITS nibbles plus the binary register. It is instantiated once and reused each SHIFT cycle.

## Test plan
- After reset, with no requests across 3 frame_starts -> digit_bcd=0x0000, digit_en=0001, overflow=0, busy=0.
- score_in=1234 with score_vld, frame_start at t+15 -> digit_bcd=0x1234, digit_en=1111 at t+16, busy low at t+16.
- score_in=12000 -> digit_bcd=0x9999, digit_en=1111, overflow=1. Then score_in=7 -> 0x0007, digit_en=0001, overflow=0.
- score_vld=57, then 300 and 42 while busy, then frames -> first 0x0057 with en 0011, then 0x0042 with en 0011; 300 is never shown.
- frame_start pulsed during SHIFT (t+5) -> no output change; outputs update at the next frame_start in PEND.
- Assert sys_rst at t+8 during SHIFT with a pending request stored -> the next cycle shows reset values. With no new score_vld, busy stays 0 indefinitely and outputs remain 0x0000/0001.
